// File: rtl/clk_ratio_loader.sv
// clk_ratio_loader: validates divider ratio requests and applies them
// only on a divided-clock period boundary, with a forced-apply timeout.
module clk_ratio_loader #(
    parameter int unsigned RESET_RATIO = 2,
    parameter int unsigned MIN_RATIO   = 2,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_ratio,
    output logic        req_ready,
    input  logic        div_clk,
    output logic [31:0] ratio,
    output logic        busy,
    output logic        applied,
    output logic        rejected,
    output logic        timed_out
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [31:0]   MIN_R    = 32'(MIN_RATIO);
    localparam logic [31:0]   RST_R    = 32'(RESET_RATIO);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]    r_state;
    logic [31:0]   r_pending;
    logic [31:0]   r_ratio;
    logic [CW-1:0] r_cnt;
    logic          r_div_prev;
    logic          r_applied;
    logic          r_rejected;
    logic          r_timed_out;

    logic w_fall;
    logic w_hs;
    logic w_legal;
    logic w_tmo;

    // Divider counter is at 0 exactly when its output falls.
    assign w_fall  = r_div_prev & ~div_clk;
    assign w_hs    = req_valid & (r_state == S_IDLE);
    assign w_legal = (req_ratio >= MIN_R);
    assign w_tmo   = (r_cnt == CNT_LAST);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_pending   <= '0;
            r_ratio     <= RST_R;
            r_cnt       <= '0;
            r_div_prev  <= 1'b0;
            r_applied   <= 1'b0;
            r_rejected  <= 1'b0;
            r_timed_out <= 1'b0;
        end else begin
            r_div_prev  <= div_clk;
            r_applied   <= 1'b0;
            r_rejected  <= 1'b0;
            r_timed_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_hs && !w_legal) begin
                        r_rejected <= 1'b1;
                    end else if (w_hs) begin
                        r_pending <= req_ratio;
                        r_cnt     <= '0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A boundary beats a coincident timeout.
                    if (w_fall || w_tmo) begin
                        r_ratio     <= r_pending;
                        r_applied   <= 1'b1;
                        r_timed_out <= ~w_fall;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state == S_WAIT);
    assign ratio     = r_ratio;
    assign applied   = r_applied;
    assign rejected  = r_rejected;
    assign timed_out = r_timed_out;
endmodule
